cordic_sched: RTL and testbench

// - Shares one 8-bit iterative CORDIC engine among NREQ requesters; round-robin arbitration.
// - Latches the winner's angle/mode, pulses engine start, waits the fixed engine latency,

---
 rtl/cordic_pkg.sv | 14 +
 rtl/cordic_sched_rr_arbiter.sv | 34 +++
 rtl/cordic_sched.sv | 108 ++++++++++
 tb/tb_cordic_sched.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC request scheduler.
package cordic_pkg;

  localparam int CORDIC_W       = 8;
  localparam int CORDIC_LATENCY = 10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sched_state_t;

endpackage

// File: rtl/cordic_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester after rr_ptr wins,
// with the search wrapping modulo NREQ.
module rr_arbiter
  import cordic_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any
);

  logic [IDW-1:0] idx;

  // Walk the requesters in priority order; the first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_sched.sv
// Shares one iterative CORDIC engine among NREQ requesters: arbitrates, issues,
// waits a fixed latency, then returns the result tagged with the requester id.
module cordic_sched
  import cordic_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int LATENCY = CORDIC_LATENCY,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [CORDIC_W*NREQ-1:0] req_theta,
  input  logic [NREQ-1:0]          req_sc,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [CORDIC_W-1:0]      rsp_value,
  output logic                     busy,
  output logic                     eng_start,
  output logic [CORDIC_W-1:0]      eng_theta,
  output logic                     eng_sc,
  input  logic [CORDIC_W-1:0]      eng_value
);

  localparam int CNT_W = $clog2(LATENCY);

  sched_state_t     state, next_state;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic             grant_any;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   id_q;
  logic [CNT_W-1:0] lat_cnt;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant_any) next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    if (lat_cnt == '0) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // req_ready is a Mealy output so acceptance happens in the same IDLE cycle.
  always_comb begin
    req_ready = '0;
    eng_start = 1'b0;
    rsp_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:    req_ready = grant;
      ISSUE:   eng_start = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // The last WAIT cycle is exactly LATENCY cycles after eng_start, so the
  // engine result is captured there and presented alongside rsp_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= IDW'(NREQ - 1);
      id_q      <= '0;
      eng_theta <= '0;
      eng_sc    <= 1'b0;
      lat_cnt   <= '0;
      rsp_value <= '0;
      rsp_id    <= '0;
    end else begin
      if (state == IDLE && grant_any) begin
        eng_theta <= req_theta[CORDIC_W*grant_idx +: CORDIC_W];
        eng_sc    <= req_sc[grant_idx];
        id_q      <= grant_idx;
        rr_ptr    <= grant_idx;
      end
      if (state == ISSUE) begin
        lat_cnt <= CNT_W'(LATENCY - 1);
      end else if (state == WAIT) begin
        if (lat_cnt != '0) begin
          lat_cnt <= lat_cnt - CNT_W'(1);
        end else begin
          rsp_value <= eng_value;
          rsp_id    <= id_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_cordic_sched.sv
// Directed self-checking bench for cordic_sched with a fixed-latency engine stub.
module tb_cordic_sched;

  localparam int NREQ = 4;
  localparam int LAT  = 10;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_theta;
  logic [NREQ-1:0]   req_sc;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_value;
  logic              busy;
  logic              eng_start;
  logic [7:0]        eng_theta;
  logic              eng_sc;
  logic [7:0]        eng_value;
  logic [7:0]        eng_result;

  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;
  int stubCnt;

  int         grantQ[$];
  int         grantCycQ[$];
  int         startCycQ[$];
  int         rspIdQ[$];
  int         rspCycQ[$];
  logic [7:0] rspValQ[$];
  logic [7:0] engThetaQ[$];
  logic       engScQ[$];
  bit         outstanding = 1'b0;
  int         grantWhileBusy = 0;
  int         badOneHot = 0;
  int         thetaDrift = 0;
  logic [7:0] startTheta = '0;
  logic       startSc = 1'b0;

  cordic_sched #(
    .NREQ    (NREQ),
    .LATENCY (LAT),
    .IDW     (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_theta (req_theta),
    .req_sc    (req_sc),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_value (rsp_value),
    .busy      (busy),
    .eng_start (eng_start),
    .eng_theta (eng_theta),
    .eng_sc    (eng_sc),
    .eng_value (eng_value)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Engine stub: the result is only valid in the cycle LAT after eng_start.
  always @(posedge clk or posedge rst) begin
    if (rst)                        stubCnt <= 0;
    else if (eng_start)             stubCnt <= 1;
    else if (stubCnt != 0 && stubCnt < 15) stubCnt <= stubCnt + 1;
  end
  assign eng_result = eng_theta + (eng_sc ? 8'h80 : 8'h01);
  assign eng_value  = (stubCnt == LAT) ? eng_result : 8'hEE;

  // Event logger sampled mid-cycle after inputs have settled.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      outstanding = 1'b0;
    end else begin
      if (req_ready != '0) begin
        if (outstanding) grantWhileBusy++;
        if (!$onehot(req_ready)) badOneHot++;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) grantQ.push_back(i);
        grantCycQ.push_back(cyc);
        outstanding = 1'b1;
      end
      if (eng_start) begin
        startCycQ.push_back(cyc);
        engThetaQ.push_back(eng_theta);
        engScQ.push_back(eng_sc);
        startTheta = eng_theta;
        startSc    = eng_sc;
      end else if (outstanding && busy && (eng_theta != startTheta || eng_sc != startSc)) begin
        thetaDrift++;
      end
      if (rsp_valid) begin
        rspIdQ.push_back(int'(rsp_id));
        rspValQ.push_back(rsp_value);
        rspCycQ.push_back(cyc);
        outstanding = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clearLogs();
    grantQ.delete(); grantCycQ.delete(); startCycQ.delete();
    rspIdQ.delete(); rspCycQ.delete(); rspValQ.delete();
    engThetaQ.delete(); engScQ.delete();
    thetaDrift = 0;
  endtask

  task automatic applyStimulus(input int idx, input logic v, input logic [7:0] th, input logic sc);
    req_valid[idx]          = v;
    req_theta[8*idx +: 8]   = th;
    req_sc[idx]             = sc;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    req_theta = '0;
    req_sc    = '0;
    waitCycles(2);
    rst = 1'b0;
    clearLogs();
  endtask

  task automatic waitRsp(input string tag, input int n, input int budget);
    int b = budget;
    while (rspIdQ.size() < n && b > 0) begin
      @(negedge clk); #3; b--;
    end
    checkOutput(tag, rspIdQ.size(), n);
  endtask

  task automatic waitGrant(input string tag, input int n, input int budget);
    int b = budget;
    while (grantQ.size() < n && b > 0) begin
      @(negedge clk); #3; b--;
    end
    checkOutput(tag, grantQ.size(), n);
  endtask

  function automatic logic [25:0] allOuts();
    return {req_ready, rsp_valid, rsp_id, rsp_value, busy, eng_start, eng_theta, eng_sc};
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int expOrder[6] = '{0, 1, 2, 3, 0, 1};
    logic [7:0] expVal[4] = '{8'h11, 8'hA0, 8'h31, 8'hC0};
    int id3Count;

    rst       = 1'b1;
    req_valid = '0;
    req_theta = '0;
    req_sc    = '0;

    // Reset state
    applyReset();
    #1 checkOutput("reset_outs", 32'(allOuts()), 32'h0);

    // Single request from requester 0
    waitCycles(1);
    applyStimulus(0, 1'b1, 8'h40, 1'b0);
    #1 checkOutput("t1_ready", 32'(req_ready), 32'h1);
    waitCycles(1);
    applyStimulus(0, 1'b0, 8'h40, 1'b0);
    #1 checkOutput("t1_start", {eng_start, busy, eng_theta}, {1'b1, 1'b1, 8'h40});
    waitRsp("t1_rsp_count", 1, 40);
    checkOutput("t1_start_lat", startCycQ[0] - grantCycQ[0], 1);
    checkOutput("t1_rsp_lat", rspCycQ[0] - grantCycQ[0], 12);
    checkOutput("t1_rsp_id", rspIdQ[0], 0);
    checkOutput("t1_rsp_value", rspValQ[0], 8'h41);
    @(negedge clk); #3;
    checkOutput("t1_after", {rsp_valid, busy, rsp_value}, {1'b0, 1'b0, 8'h41});

    // All four requesting continuously
    applyReset();
    applyStimulus(0, 1'b1, 8'h10, 1'b0);
    applyStimulus(1, 1'b1, 8'h20, 1'b1);
    applyStimulus(2, 1'b1, 8'h30, 1'b0);
    applyStimulus(3, 1'b1, 8'h40, 1'b1);
    waitRsp("t2_rsp_count", 6, 120);
    @(negedge clk);
    req_valid = '0;
    waitCycles(15);
    checkOutput("t2_grant_count", grantQ.size(), 6);
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("t2_grant%0d", k), grantQ[k], expOrder[k]);
      checkOutput($sformatf("t2_rsp_id%0d", k), rspIdQ[k], expOrder[k]);
      checkOutput($sformatf("t2_rsp_val%0d", k), rspValQ[k], expVal[expOrder[k]]);
      checkOutput($sformatf("t2_rsp_lat%0d", k), rspCycQ[k] - grantCycQ[k], 12);
      if (k > 0) checkOutput($sformatf("t2_spacing%0d", k), grantCycQ[k] - grantCycQ[k-1], 13);
    end

    // Requester 2 arrives during WAIT of requester 0's operation
    applyReset();
    applyStimulus(0, 1'b1, 8'h55, 1'b0);
    waitCycles(1);
    applyStimulus(0, 1'b0, 8'h55, 1'b0);
    waitCycles(3);
    applyStimulus(2, 1'b1, 8'h66, 1'b1);
    waitGrant("t3_grant_count", 2, 40);
    @(negedge clk);
    applyStimulus(2, 1'b0, 8'h66, 1'b1);
    waitRsp("t3_rsp_count", 2, 40);
    checkOutput("t3_grant_idx", grantQ[1], 2);
    checkOutput("t3_grant_gap", grantCycQ[1] - grantCycQ[0], 13);
    checkOutput("t3_eng_theta", engThetaQ[1], 8'h66);
    checkOutput("t3_eng_sc", engScQ[1], 1'b1);
    checkOutput("t3_rsp", {rspIdQ[1][7:0], rspValQ[1]}, {8'h02, 8'hE6});

    // Requester data changes after acceptance
    applyReset();
    applyStimulus(1, 1'b1, 8'h20, 1'b0);
    #1 checkOutput("t4_ready", 32'(req_ready), 32'h2);
    waitCycles(1);
    applyStimulus(1, 1'b0, 8'h7F, 1'b1);
    waitRsp("t4_rsp_count", 1, 40);
    checkOutput("t4_eng_theta", engThetaQ[0], 8'h20);
    checkOutput("t4_theta_drift", thetaDrift, 0);
    checkOutput("t4_rsp", {rspIdQ[0][7:0], rspValQ[0]}, {8'h01, 8'h21});

    // Reset during WAIT cycle 3 aborts the operation
    applyReset();
    applyStimulus(0, 1'b1, 8'h33, 1'b0);
    waitCycles(1);
    applyStimulus(0, 1'b0, 8'h33, 1'b0);
    waitCycles(3);
    rst = 1'b1;
    #1 checkOutput("t5_abort_outs", 32'(allOuts()), 32'h0);
    @(negedge clk);
    #1 checkOutput("t5_abort_hold", 32'(allOuts()), 32'h0);
    rst = 1'b0;
    waitCycles(20);
    checkOutput("t5_no_rsp", rspIdQ.size(), 0);
    clearLogs();
    applyStimulus(1, 1'b1, 8'h44, 1'b1);
    #1 checkOutput("t5_ready", 32'(req_ready), 32'h2);
    waitCycles(1);
    applyStimulus(1, 1'b0, 8'h44, 1'b1);
    waitRsp("t5_rsp_count", 1, 40);
    checkOutput("t5_rsp_lat", rspCycQ[0] - grantCycQ[0], 12);
    checkOutput("t5_rsp", {rspIdQ[0][7:0], rspValQ[0]}, {8'h01, 8'hC4});

    // Requester 3 pulses for one cycle while busy
    applyReset();
    applyStimulus(0, 1'b1, 8'h01, 1'b0);
    waitCycles(1);
    applyStimulus(0, 1'b0, 8'h01, 1'b0);
    waitCycles(2);
    applyStimulus(3, 1'b1, 8'h99, 1'b1);
    waitCycles(1);
    applyStimulus(3, 1'b0, 8'h99, 1'b1);
    waitRsp("t6_rsp_count", 1, 40);
    waitCycles(20);
    checkOutput("t6_grant_count", grantQ.size(), 1);
    id3Count = 0;
    foreach (rspIdQ[k]) if (rspIdQ[k] == 3) id3Count++;
    checkOutput("t6_no_id3", id3Count, 0);
    checkOutput("t6_rsp_val", rspValQ[0], 8'h02);

    checkOutput("grant_while_busy", grantWhileBusy, 0);
    checkOutput("ready_onehot", badOneHot, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
